// File: rtl/lsu_dmem.sv
// Data memory responder for the LSU lanes. Each lane gets one store port and
// one load port per cycle. Stores commit at the clock edge. Load data comes
// back right-aligned one cycle later. After reset, an internal sweep zeroes
// the array before any traffic is accepted.
module lsu_dmem #(
  parameter int NUM_PORTS   = 2,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [NUM_PORTS-1:0]   wr_en,
  input  logic [32*NUM_PORTS-1:0] wr_addr,
  input  logic [32*NUM_PORTS-1:0] wr_data,
  input  logic [2*NUM_PORTS-1:0] wr_size,
  input  logic [NUM_PORTS-1:0]   rd_en,
  input  logic [32*NUM_PORTS-1:0] rd_addr,
  output logic [32*NUM_PORTS-1:0] rd_data,
  output logic                   ready,
  output logic [NUM_PORTS-1:0]   wr_err
);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                        r_state;
  logic [AW-1:0]                 r_cnt;
  logic                          r_ready;
  logic [31:0]                   r_mem [0:DEPTH_WORDS-1];
  logic [NUM_PORTS-1:0][31:0]    r_rd_data_p1;
  logic [NUM_PORTS-1:0]          r_wr_err_p1;

  logic [NUM_PORTS-1:0][AW-1:0]  w_wr_idx;
  logic [NUM_PORTS-1:0][AW-1:0]  w_rd_idx;
  logic [NUM_PORTS-1:0][1:0]     w_wr_off;
  logic [NUM_PORTS-1:0][1:0]     w_rd_off;
  logic [NUM_PORTS-1:0][3:0]     w_wr_be;
  logic [NUM_PORTS-1:0][31:0]    w_wr_word;
  logic [NUM_PORTS-1:0]          w_wr_bad;
  logic                          w_unused;

  // Upper address bits only select aliases of the same word.
  assign w_unused = ^{wr_addr, rd_addr};

  // Decode each lane's store into word index, byte enables and lane-aligned data.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_wr_idx[p]  = wr_addr[32*p+2 +: AW];
      w_rd_idx[p]  = rd_addr[32*p+2 +: AW];
      w_wr_off[p]  = wr_addr[32*p +: 2];
      w_rd_off[p]  = rd_addr[32*p +: 2];
      w_wr_word[p] = wr_data[32*p +: 32] << {w_wr_off[p], 3'b000};
      w_wr_be[p]   = 4'b0000;
      w_wr_bad[p]  = 1'b1;
      case (wr_size[2*p +: 2])
        2'b00: begin
          w_wr_be[p]  = 4'b0001 << w_wr_off[p];
          w_wr_bad[p] = 1'b0;
        end
        2'b01: begin
          w_wr_be[p]  = 4'b0011 << w_wr_off[p];
          w_wr_bad[p] = w_wr_off[p][0];
        end
        2'b10: begin
          w_wr_be[p]  = 4'b1111;
          w_wr_bad[p] = (w_wr_off[p] != 2'b00);
        end
        default: begin
          w_wr_be[p]  = 4'b0000;
          w_wr_bad[p] = 1'b1;
        end
      endcase
      if (w_wr_bad[p]) w_wr_be[p] = 4'b0000;
    end
  end

  // Init sweep FSM: clear one word per cycle, then stay in READY until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + AW'(1);
      if (r_cnt == AW'(DEPTH_WORDS - 1)) begin
        r_state <= S_READY;
        r_ready <= 1'b1;
      end
    end
  end

  // Array writes: sweep zeroing, else per-byte stores; later lanes win a byte.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_en[p] && w_wr_be[p][b])
            r_mem[w_wr_idx[p]][8*b +: 8] <= w_wr_word[p][8*b +: 8];
        end
      end
    end
  end

  // Load response and store-error flags, registered one cycle after request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data_p1 <= '0;
      r_wr_err_p1  <= '0;
    end else if (r_state == S_INIT) begin
      r_rd_data_p1 <= '0;
      r_wr_err_p1  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wr_err_p1[p] <= wr_en[p] & w_wr_bad[p];
        if (!stall) begin
          if (rd_en[p])
            r_rd_data_p1[p] <= r_mem[w_rd_idx[p]] >> {w_rd_off[p], 3'b000};
          else
            r_rd_data_p1[p] <= '0;
        end
      end
    end
  end

  assign rd_data = r_rd_data_p1;
  assign wr_err  = r_wr_err_p1;
  assign ready   = r_ready;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: init sweep, aligned/sub-word stores and loads,
// store errors, same-cycle conflicts, stall hold, address wrap and reset.
module tb_lsu_dmem;
  localparam int NP    = 2;
  localparam int DEPTH = 64;

  logic            clk;
  logic            rst;
  logic            stall;
  logic [NP-1:0]   wr_en;
  logic [32*NP-1:0] wr_addr;
  logic [32*NP-1:0] wr_data;
  logic [2*NP-1:0] wr_size;
  logic [NP-1:0]   rd_en;
  logic [32*NP-1:0] rd_addr;
  logic [32*NP-1:0] rd_data;
  logic            ready;
  logic [NP-1:0]   wr_err;

  int checks = 0;
  int errors = 0;

  lsu_dmem #(.NUM_PORTS(NP), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .ready(ready), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    stall = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_size = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_wr(input int lane, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] size);
    wr_en[lane] = 1'b1;
    wr_addr[32*lane +: 32] = addr;
    wr_data[32*lane +: 32] = data;
    wr_size[2*lane +: 2] = size;
  endtask

  task automatic set_rd(input int lane, input logic [31:0] addr);
    rd_en[lane] = 1'b1;
    rd_addr[32*lane +: 32] = addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < DEPTH + 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL %s: ready after %0d cycles, expected %0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    int n;
    logic quiet;
    idle();
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) step();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd_data); end
    checks++;
    if (wr_err !== '0) begin errors++; $display("FAIL reset_err: got %b want 0", wr_err); end
    rst = 1'b1;
    n = 0;
    quiet = 1'b1;
    while (!ready && n < DEPTH + 20) begin
      step();
      n++;
      if (rd_data !== '0 || wr_err !== '0) quiet = 1'b0;
      if (n == 30) begin
        set_wr(0, 32'h40, 32'h12345678, 2'b10);
        set_wr(1, 32'h43, 32'h0000ABCD, 2'b01);
        set_rd(0, 32'h40);
        set_rd(1, 32'h08);
      end
      if (n == 32) idle();
    end
    idle();
    checks++;
    if (n !== DEPTH) begin errors++; $display("FAIL init_len: ready after %0d want %0d", n, DEPTH); end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL init_quiet: outputs nonzero during init, got %b want 1", quiet); end
    set_rd(0, 32'h40);
    set_rd(1, 32'h43);
    step();
    idle();
    checks++;
    if (rd_data !== 64'h0) begin errors++; $display("FAIL init_cleared: got %h want 0", rd_data); end
  endtask

  task automatic test_word_load();
    set_wr(0, 32'h10, 32'hDEADBEEF, 2'b10);
    step();
    idle();
    set_rd(0, 32'h10);
    step();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_10: got %h want DEADBEEF", rd_data[31:0]); end
    set_rd(0, 32'h11);
    step();
    checks++;
    if (rd_data[31:0] !== 32'h00DEADBE) begin errors++; $display("FAIL load_11: got %h want 00DEADBE", rd_data[31:0]); end
    set_rd(0, 32'h13);
    step();
    checks++;
    if (rd_data[31:0] !== 32'h000000DE) begin errors++; $display("FAIL load_13: got %h want 000000DE", rd_data[31:0]); end
    idle();
    step();
    checks++;
    if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL load_off: got %h want 0", rd_data[31:0]); end
  endtask

  task automatic test_subword();
    set_wr(0, 32'h21, 32'hFFFFFFAA, 2'b00);
    step();
    idle();
    set_wr(0, 32'h22, 32'hFFFF1234, 2'b01);
    step();
    idle();
    set_rd(1, 32'h20);
    step();
    checks++;
    if (rd_data[63:32] !== 32'h1234AA00) begin errors++; $display("FAIL subword: got %h want 1234AA00", rd_data[63:32]); end
    idle();
    set_wr(0, 32'h23, 32'h00005555, 2'b01);
    set_wr(1, 32'h24, 32'h77777777, 2'b11);
    step();
    checks++;
    if (wr_err !== 2'b11) begin errors++; $display("FAIL err_pulse: got %b want 11", wr_err); end
    idle();
    set_wr(1, 32'h26, 32'h00009999, 2'b10);
    set_rd(0, 32'h20);
    step();
    checks++;
    if (wr_err !== 2'b10) begin errors++; $display("FAIL err_word_misalign: got %b want 10", wr_err); end
    checks++;
    if (rd_data[31:0] !== 32'h1234AA00) begin errors++; $display("FAIL err_nowrite: got %h want 1234AA00", rd_data[31:0]); end
    idle();
    set_rd(0, 32'h24);
    step();
    checks++;
    if (wr_err !== 2'b00) begin errors++; $display("FAIL err_clear: got %b want 00", wr_err); end
    checks++;
    if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL err_nowrite2: got %h want 0", rd_data[31:0]); end
    idle();
  endtask

  task automatic test_conflict();
    set_wr(0, 32'h30, 32'h11111111, 2'b10);
    set_wr(1, 32'h30, 32'h00000022, 2'b00);
    set_rd(0, 32'h30);
    step();
    idle();
    checks++;
    if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL rbw: got %h want 0", rd_data[31:0]); end
    set_rd(0, 32'h30);
    set_rd(1, 32'h31);
    step();
    idle();
    checks++;
    if (rd_data[31:0] !== 32'h11111122) begin errors++; $display("FAIL conflict_l0: got %h want 11111122", rd_data[31:0]); end
    checks++;
    if (rd_data[63:32] !== 32'h00111111) begin errors++; $display("FAIL conflict_l1: got %h want 00111111", rd_data[63:32]); end
  endtask

  task automatic test_stall();
    set_rd(0, 32'h10);
    step();
    idle();
    stall = 1'b1;
    set_rd(0, 32'h13);
    set_wr(1, 32'h50, 32'hCAFEF00D, 2'b10);
    step();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_hold1: got %h want DEADBEEF", rd_data[31:0]); end
    idle();
    stall = 1'b1;
    set_wr(0, 32'h51, 32'h0000FFFF, 2'b01);
    step();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_hold2: got %h want DEADBEEF", rd_data[31:0]); end
    checks++;
    if (wr_err !== 2'b01) begin errors++; $display("FAIL stall_err: got %b want 01", wr_err); end
    idle();
    stall = 1'b1;
    set_rd(0, 32'h50);
    step();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_hold3: got %h want DEADBEEF", rd_data[31:0]); end
    stall = 1'b0;
    step();
    idle();
    checks++;
    if (rd_data[31:0] !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_store: got %h want CAFEF00D", rd_data[31:0]); end
  endtask

  task automatic test_wrap_reset();
    set_wr(1, 32'h10 + 4*DEPTH, 32'h5A5A5A5A, 2'b10);
    step();
    idle();
    set_rd(0, 32'h10);
    set_rd(1, 32'hFFFF0013);
    set_wr(0, 32'h61, 32'h0, 2'b10);
    step();
    checks++;
    if (rd_data !== 64'h0000005A_5A5A5A5A) begin errors++; $display("FAIL wrap: got %h want 0000005A5A5A5A5A", rd_data); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rd_data !== '0 || ready !== 1'b0 || wr_err !== '0) begin
      errors++;
      $display("FAIL async_rst: rd %h ready %b err %b want 0 0 0", rd_data, ready, wr_err);
    end
    idle();
    step();
    rst = 1'b1;
    repeat (10) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    wait_ready("mid_sweep_restart");
    set_rd(0, 32'h10);
    step();
    idle();
    checks++;
    if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL sweep_zero: got %h want 0", rd_data[31:0]); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword();
    test_conflict();
    test_stall();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
